branch_resolution_unit: RTL and testbench
=========================================

Name: branch_resolution_unit

Overview:
- Resolution end of the branch prediction path; the predictor issues predictions at decode, and this block checks them when branches resolve at the MEM stage.
- Holds an in-order queue of in-flight predictions, pushed at decode and popped at resolve.
- Compares each prediction with the actual outcome. On a mispredict it drives a pipeline flush and a corrected PC.
- Returns predictor-table update requests and keeps branch and mispredict statistics.

Parameters:
DEPTH, 4, number of in-flight prediction entries (power of two, ≥2)
FLUSH_CYCLES, 2, cycles `flush` is held high after a mispredict (≥1)
CNT_W, 32, width of the statistics counters

Ports:
clk  input  1  clock; all state updates on posedge
reset_n  input  1  asynchronous active-low reset
pred_valid  input  1  decode-stage branch prediction push
pred_taken  input  1  predicted direction
pred_target  input  32  predicted taken target
pred_fallthrough  input  32  branch PC+4
pred_index  input  8  history index used for the prediction
res_valid  input  1  MEM-stage branch resolved (pop)
res_taken  input  1  actual direction
res_target  input  32  actual taken target
queue_full  output  1  DEPTH entries held
queue_empty  output  1  no entries held
flush  output  1  squash younger pipeline stages
redirect_valid  output  1  one-cycle pulse: fetch from redirect_pc
redirect_pc  output  32  corrected fetch address
upd_valid  output  1  one-cycle pulse: predictor update
upd_taken  output  1  actual direction for update
upd_index  output  8  table index to update
err  output  1  sticky: overflow or underflow occurred
branch_count  output  CNT_W  resolved branches, saturating
mispredict_count  output  CNT_W  mispredicts, saturating

Behaviour:
- Reset (async assert, sync release): queue empty, `queue_empty`=1, all other outputs 0, FSM=IDLE.
- Queue is a circular FIFO with wrapping read/write pointers and an occupancy count of 0..DEPTH.
- Push: accepted on `pred_valid` & (!`queue_full` | `res_valid`) & state==IDLE.
  - `pred_valid` while full and no pop in the same cycle: entry dropped, `err` set.
- Pop: on `res_valid` with queue non-empty and state==IDLE.
  - `res_valid` while empty: ignored, `err` set.
  - `res_valid` in FLUSH state: ignored, no error (wrong-path branch), not counted.
- Mispredict: (`pred_taken` != `res_taken`) | (`pred_taken` & `res_taken` & `pred_target` != `res_target`), evaluated on the popped head entry.
- Correct PC: `res_target` if `res_taken`, else `pred_fallthrough` of the head entry.
- Registered outputs, 1-cycle latency. In the cycle after an accepted pop:
  - `upd_valid`=1, `upd_taken`=`res_taken`, `upd_index`=head `pred_index`.
  - `branch_count` increments.
- On a mispredicting pop, in the following cycle:
  - `redirect_valid` pulses for 1 cycle; `redirect_pc` = correct PC, held until the next redirect.
  - `mispredict_count` increments.
  - `flush`=1; FSM enters FLUSH.
  - Queue is cleared to empty (all younger entries are wrong-path). A push in the same cycle as the mispredicting pop is discarded.
- FSM:
  - IDLE -> FLUSH on a mispredicting pop.
  - FLUSH holds `flush`=1 for exactly FLUSH_CYCLES cycles (down-counter), then returns to IDLE.
  - Pushes in FLUSH are discarded silently.
- Simultaneous push and pop at full: both accepted, occupancy unchanged.
- Simultaneous push and pop at empty: push accepted, pop treated as underflow.
- Counters saturate at all-ones and never wrap.
- `err` is sticky and clears only on reset.
- Reset mid-FLUSH: immediately IDLE, `flush`=0, queue empty, counters 0.

Test Plan:
- Push 3 correct not-taken predictions, then resolve each not-taken -> 3 `upd_valid` pulses with the matching `pred_index`; `branch_count`=3, `mispredict_count`=0, no `flush`, queue empty.
- Push {taken, target 0x100, fallthrough 0x44}, resolve not-taken -> next cycle `redirect_valid`=1, `redirect_pc`=0x44; `flush` high for 2 cycles; `mispredict_count`=1.
- Push taken target 0x200, resolve taken target 0x300 -> mispredict, `redirect_pc`=0x300; 2 younger queued entries discarded, queue empty.
- Push 5 entries with DEPTH=4 and no pops -> 5th dropped, `err`=1, `queue_full`=1; then push+pop in the same cycle -> occupancy stays 4.
- `res_valid` with empty queue -> `err`=1, no `upd_valid`; assert `reset_n`=0 during FLUSH -> `flush`=0 asynchronously, all counters 0.

Source files
------------

// File: rtl/branch_resolution_unit.sv
// Branch resolution unit: holds in-flight predictions in an in-order queue,
// checks each against the resolved outcome, and drives flush/redirect on a
// mispredict while returning predictor updates and statistics.
module branch_resolution_unit #(
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pred_valid,
  input  logic             pred_taken,
  input  logic [31:0]      pred_target,
  input  logic [31:0]      pred_fallthrough,
  input  logic [7:0]       pred_index,
  input  logic             res_valid,
  input  logic             res_taken,
  input  logic [31:0]      res_target,
  output logic             queue_full,
  output logic             queue_empty,
  output logic             flush,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             upd_valid,
  output logic             upd_taken,
  output logic [7:0]       upd_index,
  output logic             err,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [PW:0]   FULL_CNT   = (PW+1)'(DEPTH);
  localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYCLES - 1);

  typedef enum logic {IDLE, FLUSH} state_t;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
    logic [31:0] fallthrough;
    logic [7:0]  index;
  } entry_t;

  entry_t [DEPTH-1:0] entries_q, entries_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PW:0]        count_q, count_d;
  state_t             state_q, state_d;
  logic [FW-1:0]      flush_cnt_q, flush_cnt_d;
  logic               redirect_valid_q, redirect_valid_d;
  logic [31:0]        redirect_pc_q, redirect_pc_d;
  logic               upd_valid_q, upd_valid_d;
  logic               upd_taken_q, upd_taken_d;
  logic [7:0]         upd_index_q, upd_index_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   branch_count_q, branch_count_d;
  logic [CNT_W-1:0]   mispredict_count_q, mispredict_count_d;

  entry_t head;
  logic   in_idle, is_full, is_empty;
  logic   push_ok, pop_ok, overflow, underflow, mispredict;

  // Next-state logic: queue bookkeeping, mispredict detection, FSM and stats.
  always_comb begin
    entries_d          = entries_q;
    wr_ptr_d           = wr_ptr_q;
    rd_ptr_d           = rd_ptr_q;
    count_d            = count_q;
    state_d            = state_q;
    flush_cnt_d        = flush_cnt_q;
    redirect_valid_d   = 1'b0;
    redirect_pc_d      = redirect_pc_q;
    upd_valid_d        = 1'b0;
    upd_taken_d        = upd_taken_q;
    upd_index_d        = upd_index_q;
    err_d              = err_q;
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;

    head      = entries_q[rd_ptr_q];
    in_idle   = (state_q == IDLE);
    is_full   = (count_q == FULL_CNT);
    is_empty  = (count_q == '0);
    push_ok   = pred_valid && in_idle && (!is_full || res_valid);
    pop_ok    = res_valid && in_idle && !is_empty;
    overflow  = pred_valid && in_idle && is_full && !res_valid;
    underflow = res_valid && in_idle && is_empty;
    mispredict = pop_ok &&
                 ((head.taken != res_taken) ||
                  (head.taken && res_taken && (head.target != res_target)));

    if (overflow || underflow) begin
      err_d = 1'b1;
    end

    if (pop_ok) begin
      upd_valid_d = 1'b1;
      upd_taken_d = res_taken;
      upd_index_d = head.index;
      if (branch_count_q != {CNT_W{1'b1}}) begin
        branch_count_d = branch_count_q + CNT_W'(1);
      end
    end

    if (mispredict) begin
      // Everything younger than the mispredicted branch is wrong-path, so the
      // queue is emptied and a same-cycle push is dropped.
      redirect_valid_d = 1'b1;
      redirect_pc_d    = res_taken ? res_target : head.fallthrough;
      if (mispredict_count_q != {CNT_W{1'b1}}) begin
        mispredict_count_d = mispredict_count_q + CNT_W'(1);
      end
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      state_d     = FLUSH;
      flush_cnt_d = FLUSH_LOAD;
    end else begin
      if (push_ok) begin
        entries_d[wr_ptr_q] = '{taken: pred_taken, target: pred_target,
                                fallthrough: pred_fallthrough, index: pred_index};
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (push_ok && !pop_ok) begin
        count_d = count_q + (PW+1)'(1);
      end else if (pop_ok && !push_ok) begin
        count_d = count_q - (PW+1)'(1);
      end
      if (state_q == FLUSH) begin
        if (flush_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          flush_cnt_d = flush_cnt_q - FW'(1);
        end
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      entries_q          <= '0;
      wr_ptr_q           <= '0;
      rd_ptr_q           <= '0;
      count_q            <= '0;
      state_q            <= IDLE;
      flush_cnt_q        <= '0;
      redirect_valid_q   <= 1'b0;
      redirect_pc_q      <= '0;
      upd_valid_q        <= 1'b0;
      upd_taken_q        <= 1'b0;
      upd_index_q        <= '0;
      err_q              <= 1'b0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      entries_q          <= entries_d;
      wr_ptr_q           <= wr_ptr_d;
      rd_ptr_q           <= rd_ptr_d;
      count_q            <= count_d;
      state_q            <= state_d;
      flush_cnt_q        <= flush_cnt_d;
      redirect_valid_q   <= redirect_valid_d;
      redirect_pc_q      <= redirect_pc_d;
      upd_valid_q        <= upd_valid_d;
      upd_taken_q        <= upd_taken_d;
      upd_index_q        <= upd_index_d;
      err_q              <= err_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign queue_full       = (count_q == FULL_CNT);
  assign queue_empty      = (count_q == '0);
  assign flush            = (state_q == FLUSH);
  assign redirect_valid   = redirect_valid_q;
  assign redirect_pc      = redirect_pc_q;
  assign upd_valid        = upd_valid_q;
  assign upd_taken        = upd_taken_q;
  assign upd_index        = upd_index_q;
  assign err              = err_q;
  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Self-checking bench for branch_resolution_unit: a queue-based reference
// model predicts queue/flush/stat state, and a scoreboard holds the expected
// update/redirect for each accepted resolve until it appears one cycle later.
module tb_branch_resolution_unit;

  localparam int DEPTH        = 4;
  localparam int FLUSH_CYCLES = 2;
  localparam int CNT_W        = 4;
  localparam int CMAX         = (1 << CNT_W) - 1;

  logic             clk;
  logic             reset_n;
  logic             pred_valid;
  logic             pred_taken;
  logic [31:0]      pred_target;
  logic [31:0]      pred_fallthrough;
  logic [7:0]       pred_index;
  logic             res_valid;
  logic             res_taken;
  logic [31:0]      res_target;
  logic             queue_full;
  logic             queue_empty;
  logic             flush;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             upd_valid;
  logic             upd_taken;
  logic [7:0]       upd_index;
  logic             err;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispredict_count;

  branch_resolution_unit #(
    .DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_target(pred_target),
    .pred_fallthrough(pred_fallthrough), .pred_index(pred_index),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .queue_full(queue_full), .queue_empty(queue_empty), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .upd_valid(upd_valid), .upd_taken(upd_taken), .upd_index(upd_index),
    .err(err), .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  typedef struct {
    logic        taken;
    logic [31:0] target;
    logic [31:0] fall;
    logic [7:0]  idx;
  } pred_t;

  typedef struct {
    logic        taken;
    logic [7:0]  idx;
    logic        mis;
  } exp_t;

  pred_t mq[$];
  exp_t  sb[$];
  int    flush_left;
  logic  exp_err;
  int    exp_branch;
  int    exp_mis;
  logic [31:0] exp_pc;
  int    tests;
  int    fails;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: counts it and reports any difference.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    sb.delete();
    flush_left = 0;
    exp_err    = 1'b0;
    exp_branch = 0;
    exp_mis    = 0;
    exp_pc     = '0;
  endtask

  // Drive one cycle of inputs and advance the reference model to its post-edge state.
  task automatic applyStimulus(input logic pv, input logic pt, input logic [31:0] ptg,
                               input logic [31:0] pf, input logic [7:0] pi,
                               input logic rv, input logic rt, input logic [31:0] rtg);
    pred_t h;
    logic  mis;
    logic  pop_ok;
    logic  push_ok;
    logic [31:0] pc;
    pred_valid = pv; pred_taken = pt; pred_target = ptg;
    pred_fallthrough = pf; pred_index = pi;
    res_valid = rv; res_taken = rt; res_target = rtg;
    mis = 1'b0;
    if (flush_left > 0) begin
      flush_left--;
    end else begin
      pop_ok  = rv && (mq.size() > 0);
      push_ok = pv && ((mq.size() < DEPTH) || rv);
      if (rv && mq.size() == 0) exp_err = 1'b1;
      if (pv && mq.size() == DEPTH && !rv) exp_err = 1'b1;
      if (pop_ok) begin
        h   = mq.pop_front();
        mis = (h.taken != rt) || (h.taken && rt && (h.target != rtg));
        pc  = rt ? rtg : h.fall;
        sb.push_back('{taken: rt, idx: h.idx, mis: mis});
        if (exp_branch < CMAX) exp_branch++;
        if (mis) begin
          if (exp_mis < CMAX) exp_mis++;
          exp_pc = pc;
          mq.delete();
          flush_left = FLUSH_CYCLES;
        end
      end
      if (push_ok && !mis) begin
        mq.push_back('{taken: pt, target: ptg, fall: pf, idx: pi});
      end
    end
  endtask

  // Compare every visible output against the model after an edge.
  task automatic checkOutput();
    exp_t e;
    chk("flush",            32'(flush),            32'(flush_left > 0));
    chk("queue_empty",      32'(queue_empty),      32'(mq.size() == 0));
    chk("queue_full",       32'(queue_full),       32'(mq.size() == DEPTH));
    chk("err",              32'(err),              32'(exp_err));
    chk("branch_count",     32'(branch_count),     32'(exp_branch));
    chk("mispredict_count", 32'(mispredict_count), 32'(exp_mis));
    chk("redirect_pc",      redirect_pc,           exp_pc);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("upd_valid",      32'(upd_valid),      32'(1));
      chk("upd_taken",      32'(upd_taken),      32'(e.taken));
      chk("upd_index",      32'(upd_index),      32'(e.idx));
      chk("redirect_valid", 32'(redirect_valid), 32'(e.mis));
    end else begin
      chk("upd_valid_idle",      32'(upd_valid),      32'(0));
      chk("redirect_valid_idle", 32'(redirect_valid), 32'(0));
    end
  endtask

  task automatic step(input logic pv, input logic pt, input logic [31:0] ptg,
                      input logic [31:0] pf, input logic [7:0] pi,
                      input logic rv, input logic rt, input logic [31:0] rtg);
    applyStimulus(pv, pt, ptg, pf, pi, rv, rt, rtg);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 32'h0, 8'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic pushNt(input logic [7:0] pi);
    step(1'b1, 1'b0, 32'h900, 32'h1000 + 32'(pi), pi, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic popNt();
    step(1'b0, 1'b0, 32'h0, 32'h0, 8'h0, 1'b1, 1'b0, 32'h0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    modelReset();
    reset_n = 1'b1;
    pred_valid = 1'b0; pred_taken = 1'b0; pred_target = '0;
    pred_fallthrough = '0; pred_index = '0;
    res_valid = 1'b0; res_taken = 1'b0; res_target = '0;

    // Reset state
    #2 reset_n = 1'b0;
    #2;
    checkOutput();
    #8 reset_n = 1'b1;

    // Three correct not-taken branches
    pushNt(8'h01);
    pushNt(8'h02);
    pushNt(8'h03);
    popNt();
    popNt();
    popNt();
    idle();

    // Predicted taken, actually not-taken: redirect to fallthrough
    step(1'b1, 1'b1, 32'h100, 32'h44, 8'h21, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 8'h0, 1'b1, 1'b0, 32'h0);
    chk("redirect_pc_nt", redirect_pc, 32'h44);
    idle();
    idle();
    idle();

    // Taken with wrong target; younger entries discarded, same-cycle push dropped
    step(1'b1, 1'b1, 32'h200, 32'h84, 8'h30, 1'b0, 1'b0, 32'h0);
    pushNt(8'h31);
    pushNt(8'h32);
    step(1'b1, 1'b0, 32'h900, 32'h2000, 8'h33, 1'b1, 1'b1, 32'h300);
    chk("redirect_pc_tgt", redirect_pc, 32'h300);
    chk("queue_empty_after_mis", 32'(queue_empty), 32'(1));
    step(1'b1, 1'b0, 32'h900, 32'h2004, 8'h34, 1'b1, 1'b0, 32'h0);
    idle();
    idle();

    // Overflow, then simultaneous push+pop at full
    pushNt(8'h40);
    pushNt(8'h41);
    pushNt(8'h42);
    pushNt(8'h43);
    pushNt(8'h44);
    step(1'b1, 1'b0, 32'h900, 32'h1045, 8'h45, 1'b1, 1'b0, 32'h0);
    popNt();
    popNt();
    popNt();
    popNt();
    idle();

    // Drive the statistics counter into saturation
    pushNt(8'h50);
    for (int i = 0; i < 18; i++) begin
      step(1'b1, 1'b0, 32'h900, 32'h1051 + 32'(i), 8'(8'h51 + i), 1'b1, 1'b0, 32'h0);
    end
    popNt();
    idle();

    // Reset asserted while in FLUSH
    step(1'b1, 1'b1, 32'h500, 32'h504, 8'h60, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 8'h0, 1'b1, 1'b0, 32'h0);
    reset_n = 1'b0;
    #1;
    modelReset();
    chk("flush_async_reset", 32'(flush), 32'(0));
    checkOutput();
    #2 reset_n = 1'b1;
    idle();

    // Underflow, then push+pop on empty queue
    popNt();
    idle();
    step(1'b1, 1'b0, 32'h900, 32'h1070, 8'h70, 1'b1, 1'b0, 32'h0);
    popNt();
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
